// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock)
// with start/busy/done handshake, overflow saturation and optional leading-zero blanking.
module bin_to_bcd_seq #(
   parameter int WIDTH = 16,
   parameter int COUNT = 5,
   parameter int LZB   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     bin,
   output logic                 busy,
   output logic                 done,
   output logic [COUNT*4-1:0]   bcd,
   output logic                 overflow
);

   localparam int BW = COUNT * 4;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] binreg_q, binreg_d;
   logic [BW-1:0]    scratch_q, scratch_d;
   logic             carry_q, carry_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    scratch_shift;
   logic             carry_nxt;
   logic [BW-1:0]    result;
   logic             lead;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      binreg_d  = binreg_q;
      scratch_d = scratch_q;
      carry_d   = carry_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      adj       = '0;
      lead      = 1'b1;

      for (int unsigned i = 0; i < COUNT; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         else                             adj[4*i +: 4] = scratch_q[4*i +: 4];
      end

      scratch_shift = {adj[BW-2:0], binreg_q[WIDTH-1]};
      // Any bit pushed out of the top digit means the value reached 10^COUNT.
      carry_nxt     = carry_q | adj[BW-1];

      result = scratch_shift;
      if (carry_nxt) begin
         result = {COUNT{4'h9}};
      end else if (LZB != 0) begin
         for (int unsigned k = 0; k < COUNT - 1; k++) begin
            if (lead && (scratch_shift[4*(COUNT-1-k) +: 4] == 4'd0)) result[4*(COUNT-1-k) +: 4] = 4'hF;
            else                                                      lead = 1'b0;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               binreg_d  = bin;
               scratch_d = '0;
               carry_d   = 1'b0;
               cnt_d     = CW'(WIDTH);
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            scratch_d = scratch_shift;
            binreg_d  = binreg_q << 1;
            carry_d   = carry_nxt;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = result;
               ovf_d   = carry_nxt;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         binreg_q  <= '0;
         scratch_q <= '0;
         carry_q   <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         binreg_q  <= binreg_d;
         scratch_q <= scratch_d;
         carry_q   <= carry_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy     = (state_q == ST_SHIFT);
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = ovf_q;

endmodule
